// File: rtl/fakeram_port_driver.sv
// Port driver for a single-port fake SRAM macro.
// After reset it can zero-fill the whole array. It then accepts read and
// write requests, drives the SRAM from registered outputs, and returns read
// data through a 4-entry response FIFO with valid/yumi handshaking.
module fakeram_port_driver #(
  parameter int els_p        = 512,
  parameter int width_p      = 64,
  parameter int addr_width_p = 9,
  parameter int init_zero_p  = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,

  input  logic                    v_i,
  output logic                    ready_o,
  input  logic                    w_i,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic [width_p-1:0]      data_i,
  input  logic [width_p-1:0]      mask_i,

  output logic                    v_o,
  output logic [width_p-1:0]      data_o,
  input  logic                    yumi_i,

  output logic                    init_done_o,

  output logic                    sram_ce_o,
  output logic                    sram_we_o,
  output logic [addr_width_p-1:0] sram_addr_o,
  output logic [width_p-1:0]      sram_wd_o,
  output logic [width_p-1:0]      sram_w_mask_o,
  input  logic [width_p-1:0]      sram_rd_i
);

  // The sweep counter relies on the array filling the whole address space.
  if (els_p != (1 << addr_width_p)) begin : g_bad_els
    $error("fakeram_port_driver: els_p must equal 2**addr_width_p");
  end

  typedef enum logic {S_INIT, S_RUN} state_e;

  localparam state_e RESET_STATE = (init_zero_p != 0) ? S_INIT : S_RUN;

  state_e                    state;
  logic [addr_width_p:0]     init_cnt;    // MSB set once every address has been written
  logic                      init_done_r;
  logic [2:0]                out_cnt;     // reads accepted but not yet consumed
  logic                      rd_pend1;    // read on the SRAM pins this cycle
  logic                      rd_pend2;    // sram_rd_i holds read data this cycle

  logic [1:0]                wr_ptr;
  logic [1:0]                rd_ptr;
  logic [2:0]                buf_cnt;
  logic [width_p-1:0]        buf_mem [4];

  logic                      accept;
  logic                      rd_accept;
  logic                      yumi_eff;

  // Credit-based acceptance: out_cnt counts in-flight plus buffered reads, so
  // the FIFO can never overflow and ready_o never depends on v_i/w_i.
  assign ready_o     = init_done_r & (out_cnt < 3'd4);
  assign accept      = v_i & ready_o;
  assign rd_accept   = accept & ~w_i;
  assign v_o         = (buf_cnt != 3'd0);
  assign yumi_eff    = yumi_i & v_o;
  assign data_o      = v_o ? buf_mem[rd_ptr] : '0;
  assign init_done_o = init_done_r;

  // Control FSM, registered SRAM drive, read pipeline and credit counter.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= RESET_STATE;
      init_cnt      <= '0;
      init_done_r   <= 1'b0;
      out_cnt       <= '0;
      rd_pend1      <= 1'b0;
      rd_pend2      <= 1'b0;
      sram_ce_o     <= 1'b0;
      sram_we_o     <= 1'b0;
      sram_addr_o   <= '0;
      sram_wd_o     <= '0;
      sram_w_mask_o <= '0;
    end else begin
      sram_ce_o     <= 1'b0;
      sram_we_o     <= 1'b0;
      sram_addr_o   <= '0;
      sram_wd_o     <= '0;
      sram_w_mask_o <= '0;
      rd_pend1      <= 1'b0;
      rd_pend2      <= rd_pend1;

      case (state)
        S_INIT: begin
          if (init_cnt[addr_width_p]) begin
            state       <= S_RUN;
            init_done_r <= 1'b1;
          end else begin
            sram_ce_o     <= 1'b1;
            sram_we_o     <= 1'b1;
            sram_addr_o   <= init_cnt[addr_width_p-1:0];
            sram_wd_o     <= '0;
            sram_w_mask_o <= '1;
            init_cnt      <= init_cnt + 1'b1;
          end
        end
        S_RUN: begin
          init_done_r <= 1'b1;
          if (accept) begin
            sram_ce_o     <= 1'b1;
            sram_we_o     <= w_i;
            sram_addr_o   <= addr_i;
            sram_wd_o     <= w_i ? data_i : '0;
            sram_w_mask_o <= w_i ? mask_i : '0;
            rd_pend1      <= ~w_i;
          end
        end
        default: state <= RESET_STATE;
      endcase

      case ({rd_accept, yumi_eff})
        2'b10:   out_cnt <= out_cnt + 3'd1;
        2'b01:   out_cnt <= out_cnt - 3'd1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // Response FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      buf_cnt <= '0;
    end else begin
      if (rd_pend2) wr_ptr <= wr_ptr + 2'd1;
      if (yumi_eff) rd_ptr <= rd_ptr + 2'd1;
      case ({rd_pend2, yumi_eff})
        2'b10:   buf_cnt <= buf_cnt + 3'd1;
        2'b01:   buf_cnt <= buf_cnt - 3'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  // Response FIFO storage; contents are only observed while v_o is high.
  always_ff @(posedge clk_i) begin
    if (rd_pend2) buf_mem[wr_ptr] <= sram_rd_i;
  end

endmodule

// File: tb/tb_fakeram_port_driver.sv
// Scoreboard bench for fakeram_port_driver with a behavioural SRAM model.
module tb_fakeram_port_driver;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        v_i;
  logic        ready_o;
  logic        w_i;
  logic [8:0]  addr_i;
  logic [63:0] data_i;
  logic [63:0] mask_i;
  logic        v_o;
  logic [63:0] data_o;
  logic        yumi_i;
  logic        init_done_o;
  logic        sram_ce_o;
  logic        sram_we_o;
  logic [8:0]  sram_addr_o;
  logic [63:0] sram_wd_o;
  logic [63:0] sram_w_mask_o;
  logic [63:0] sram_rd_i;

  logic        yumi_en;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic [63:0] data;
    int          acc;
    bit          exact;
  } exp_t;
  exp_t exp_q[$];

  logic [63:0] mem [512];
  logic [63:0] rd_q;

  fakeram_port_driver #(
    .els_p(512),
    .width_p(64),
    .addr_width_p(9),
    .init_zero_p(1)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .v_i(v_i),
    .ready_o(ready_o),
    .w_i(w_i),
    .addr_i(addr_i),
    .data_i(data_i),
    .mask_i(mask_i),
    .v_o(v_o),
    .data_o(data_o),
    .yumi_i(yumi_i),
    .init_done_o(init_done_o),
    .sram_ce_o(sram_ce_o),
    .sram_we_o(sram_we_o),
    .sram_addr_o(sram_addr_o),
    .sram_wd_o(sram_wd_o),
    .sram_w_mask_o(sram_w_mask_o),
    .sram_rd_i(sram_rd_i)
  );

  always #5 clk_i = ~clk_i;

  assign yumi_i    = yumi_en & v_o;
  assign sram_rd_i = rd_q;

  always @(posedge clk_i) cyc <= cyc + 1;

  // SRAM model; reseeded with junk during reset so the zero-fill is observable.
  always @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 512; i++) mem[i] <= 64'hBADC_0FFE_E0DD_F00D ^ 64'(i);
    end else if (sram_ce_o) begin
      if (sram_we_o)
        mem[sram_addr_o] <= (mem[sram_addr_o] & ~sram_w_mask_o) | (sram_wd_o & sram_w_mask_o);
      else
        rd_q <= mem[sram_addr_o];
    end
  end

  task automatic chk(input bit ok, input string name, input string act, input string req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %s, expected %s", name, act, req);
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'hC0DE_0000_5A5A_0000 | (64'(i) << 32) | 64'(i);
  endfunction

  // Monitor: pop the scoreboard whenever a response is consumed.
  always @(negedge clk_i) begin
    if (!reset_i && v_o === 1'b1 && yumi_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_response", $sformatf("data %h", data_o), "no response");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk(data_o === e.data, "resp_data", $sformatf("%h", data_o), $sformatf("%h", e.data));
        if (e.exact)
          chk(cyc == e.acc + 3, "resp_latency", $sformatf("cycle %0d", cyc),
              $sformatf("cycle %0d", e.acc + 3));
        else
          chk(cyc >= e.acc + 3, "resp_min_latency", $sformatf("cycle %0d", cyc),
              $sformatf(">= cycle %0d", e.acc + 3));
      end
    end
  end

  // Issue one request, waiting for ready_o; returns at #1 after the accepting edge.
  task automatic do_req(input bit w, input logic [8:0] a, input logic [63:0] d,
                        input logic [63:0] m, input logic [63:0] exp_d, input bit exact,
                        output int waited);
    bit acc;
    acc    = 1'b0;
    waited = 0;
    v_i = 1'b1; w_i = w; addr_i = a; data_i = d; mask_i = m;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk_i);
      if (ready_o === 1'b1) begin
        exp_t e;
        e.data = exp_d; e.acc = cyc; e.exact = exact;
        if (!w) exp_q.push_back(e);
        acc = 1'b1;
        break;
      end
      waited++;
      @(posedge clk_i); #1;
    end
    if (!acc) begin
      chk(1'b0, "req_timeout", "ready_o never high", "request accepted");
      v_i = 1'b0;
      return;
    end
    @(posedge clk_i); #1;
    v_i = 1'b0;
    chk(sram_ce_o === 1'b1 && sram_we_o === w && sram_addr_o === a &&
        sram_wd_o === (w ? d : 64'd0) && sram_w_mask_o === (w ? m : 64'd0), "sram_issue",
        $sformatf("ce=%b we=%b addr=%h wd=%h mask=%h", sram_ce_o, sram_we_o, sram_addr_o,
                  sram_wd_o, sram_w_mask_o),
        $sformatf("ce=1 we=%b addr=%h wd=%h mask=%h", w, a, (w ? d : 64'd0), (w ? m : 64'd0)));
  endtask

  // Call at #1 after the edge on which reset was released.
  task automatic init_sweep();
    for (int i = 0; i < 512; i++) begin
      @(posedge clk_i); #1;
      chk(sram_ce_o === 1'b1 && sram_we_o === 1'b1 && sram_addr_o === 9'(i) &&
          sram_wd_o === 64'd0 && sram_w_mask_o === '1 && ready_o === 1'b0 &&
          init_done_o === 1'b0 && v_o === 1'b0, "init_sweep",
          $sformatf("ce=%b we=%b addr=%0d wd=%h mask=%h ready=%b done=%b v=%b", sram_ce_o,
                    sram_we_o, sram_addr_o, sram_wd_o, sram_w_mask_o, ready_o, init_done_o, v_o),
          $sformatf("ce=1 we=1 addr=%0d wd=0 mask=all-ones ready=0 done=0 v=0", i));
    end
    @(posedge clk_i); #1;
    chk(init_done_o === 1'b1 && sram_ce_o === 1'b0 && ready_o === 1'b1, "init_done_rise",
        $sformatf("done=%b ce=%b ready=%b", init_done_o, sram_ce_o, ready_o),
        "done=1 ce=0 ready=1");
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk_i); #1;
    end
    chk(exp_q.size() == 0, "drain", $sformatf("%0d pending", exp_q.size()), "0 pending");
  endtask

  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_i); #1;
      chk(sram_ce_o === 1'b0 && sram_we_o === 1'b0 && sram_addr_o === 9'd0 &&
          sram_wd_o === 64'd0 && sram_w_mask_o === 64'd0, "idle_sram",
          $sformatf("ce=%b we=%b addr=%h wd=%h mask=%h", sram_ce_o, sram_we_o, sram_addr_o,
                    sram_wd_o, sram_w_mask_o), "all zero");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int stalls;
    int first_y;
    int acc5;

    reset_i = 1'b1; v_i = 1'b0; w_i = 1'b0; addr_i = '0; data_i = '0; mask_i = '0;
    yumi_en = 1'b0;

    #12;
    chk(ready_o === 1'b0 && v_o === 1'b0 && init_done_o === 1'b0 && sram_ce_o === 1'b0 &&
        sram_we_o === 1'b0 && sram_addr_o === 9'd0 && sram_wd_o === 64'd0 &&
        sram_w_mask_o === 64'd0 && data_o === 64'd0, "reset_outputs",
        $sformatf("ready=%b v=%b done=%b ce=%b we=%b addr=%h", ready_o, v_o, init_done_o,
                  sram_ce_o, sram_we_o, sram_addr_o), "all zero");

    @(posedge clk_i); #1;
    reset_i = 1'b0;
    init_sweep();

    yumi_en = 1'b1;
    do_req(1'b0, 9'd5, 64'd0, 64'd0, 64'd0, 1'b0, w);
    drain();

    // masked write merge
    do_req(1'b1, 9'h1A, 64'hFFFF_FFFF_FFFF_FFFF, '1, 64'd0, 1'b0, w);
    do_req(1'b1, 9'h1A, 64'hDEAD_BEEF_0123_4567, 64'hFFFF_FFFF_0000_0000, 64'd0, 1'b0, w);
    do_req(1'b0, 9'h1A, 64'd0, 64'd0, 64'hDEAD_BEEF_FFFF_FFFF, 1'b0, w);
    drain();

    for (int i = 0; i < 100; i++)
      do_req(1'b1, 9'(9'h40 + i), pat(i), '1, 64'd0, 1'b0, w);

    // back-pressure: four reads fill the credits, the fifth waits for a yumi
    yumi_en = 1'b0;
    for (int i = 0; i < 4; i++)
      do_req(1'b0, 9'(9'h40 + i), 64'd0, 64'd0, pat(i), 1'b0, w);
    chk(ready_o === 1'b0, "ready_low_after_4", $sformatf("%b", ready_o), "0");
    v_i = 1'b1; w_i = 1'b0; addr_i = 9'h44; data_i = '0; mask_i = '0;
    first_y = -1; acc5 = -1;
    for (int k = 0; k < 30; k++) begin
      if (v_o === 1'b1 && first_y < 0) begin
        yumi_en = 1'b1;
        first_y = cyc;
      end
      @(negedge clk_i);
      if (ready_o === 1'b1) begin
        exp_t e;
        e.data = pat(4); e.acc = cyc; e.exact = 1'b0;
        exp_q.push_back(e);
        acc5 = cyc;
        break;
      end
      @(posedge clk_i); #1;
    end
    @(posedge clk_i); #1;
    v_i = 1'b0;
    chk(first_y >= 0 && acc5 == first_y + 1, "fifth_accept_cycle", $sformatf("%0d", acc5),
        $sformatf("%0d (first yumi %0d + 1)", first_y + 1, first_y));
    yumi_en = 1'b1;
    drain();

    // streaming with yumi held high
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      do_req(1'b0, 9'(9'h40 + i), 64'd0, 64'd0, pat(i), 1'b1, w);
      stalls += w;
    end
    chk(stalls == 0, "stream_no_stall", $sformatf("%0d stall cycles", stalls), "0 stall cycles");
    drain();

    idle_check(5);

    // reset with reads outstanding
    yumi_en = 1'b0;
    for (int i = 0; i < 3; i++)
      do_req(1'b0, 9'(9'h40 + i), 64'd0, 64'd0, pat(i), 1'b0, w);
    chk(v_o === 1'b1 && sram_ce_o === 1'b1 && ready_o === 1'b1, "pre_reset_busy",
        $sformatf("v=%b ce=%b ready=%b", v_o, sram_ce_o, ready_o), "v=1 ce=1 ready=1");
    #2;
    reset_i = 1'b1;
    #1;
    chk(v_o === 1'b0 && ready_o === 1'b0 && sram_ce_o === 1'b0 && init_done_o === 1'b0,
        "async_reset", $sformatf("v=%b ready=%b ce=%b done=%b", v_o, ready_o, sram_ce_o,
                                 init_done_o), "all 0");
    exp_q.delete();
    yumi_en = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    init_sweep();

    do_req(1'b0, 9'h1A, 64'd0, 64'd0, 64'd0, 1'b0, w);
    drain();
    idle_check(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
